// File: rtl/bpfcap_dma.sv
// bpfcap_dma: packet-buffer copy engine for the capture path.
// Copies [SRC_BEGIN, SRC_END) to DST_ADDR through an internal FIFO, using
// Avalon-MM read bursts on m0 and write bursts on m1, with waitrequest
// honoured on both masters.
//
// Ports:
//   clk, reset (async, active-low)
//   avs_s0_*  : register slave (8 word registers, readdata registered)
//   avm_m0_*  : read master (address, read, burstcount, readdata, valid, wait)
//   avm_m1_*  : write master (address, writedata, write, burstcount, wait)
//   irq       : level interrupt, DONE & IRQ_EN
//
// Optional feature: define BPFCAP_DMA_PERF_EN to enable the busy-cycle
// counter at register 6 (otherwise register 6 reads 0).
//
// State tables
//   read FSM  | meaning
//   RD_IDLE   | no read burst in progress
//   RD_REQ    | read request asserted, waiting for acceptance
//   RD_DATA   | request accepted, collecting rd_beats_q returning beats
//   write FSM | meaning
//   WR_IDLE   | no write burst in progress
//   WR_BURST  | write burst in progress, wr_beats_q beats left
module bpfcap_dma #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_s0_address,
    input  logic [31:0]       avs_s0_writedata,
    input  logic              avs_s0_write,
    input  logic              avs_s0_read,
    output logic [31:0]       avs_s0_readdata,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read,
    output logic [15:0]       avm_m0_burstcount,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_readdatavalid,
    input  logic              avm_m0_waitrequest,
    output logic [ADDR_W-1:0] avm_m1_address,
    output logic [DATA_W-1:0] avm_m1_writedata,
    output logic              avm_m1_write,
    output logic [15:0]       avm_m1_burstcount,
    input  logic              avm_m1_waitrequest,
    output logic              irq
);
    localparam int BPW   = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] MAX_B = ADDR_W'(MAX_BURST);
    localparam logic [ADDR_W-1:0] BPW_A = ADDR_W'(BPW);

    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_DATA} rd_state_t;
    typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;

    rd_state_t         rd_state_q, rd_state_d;
    wr_state_t         wr_state_q, wr_state_d;
    logic              irq_en_q, irq_en_d, busy_q, busy_d, done_q, done_d;
    logic              err_q, err_d, aborted_q, aborted_d, abort_pend_q, abort_pend_d;
    logic [ADDR_W-1:0] src_begin_q, src_begin_d, src_end_q, src_end_d, dst_addr_q, dst_addr_d;
    logic [ADDR_W-1:0] rd_src_q, rd_src_d, rd_rem_q, rd_rem_d;
    logic [ADDR_W-1:0] wr_dst_q, wr_dst_d, wr_rem_q, wr_rem_d;
    logic [15:0]       rd_len_q, rd_len_d, rd_beats_q, rd_beats_d;
    logic [15:0]       wr_len_q, wr_len_d, wr_beats_q, wr_beats_d;
    logic [31:0]       bytes_q, bytes_d, rdata_q, rdata_d, perf_rd;
    logic [PTR_W-1:0]  fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d, rd_free;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic [ADDR_W-1:0] len, words, rd_n, wr_m;
    logic              len_bad, start_cmd, abort_cmd, start_acc, push, pop, flush, rd_go, wr_go;

    assign len       = src_end_q - src_begin_q;
    assign words     = len / BPW_A;
    assign len_bad   = (len == '0) || ((len % BPW_A) != '0) || (src_end_q < src_begin_q);
    assign start_cmd = avs_s0_write && (avs_s0_address == 3'd0) && avs_s0_writedata[0];
    assign abort_cmd = avs_s0_write && (avs_s0_address == 3'd0) && avs_s0_writedata[2];
    assign start_acc = start_cmd && !abort_cmd && !busy_q && !len_bad;

    // Beats of a burst being drained after ABORT are dropped, not pushed.
    assign push  = (rd_state_q == RD_DATA) && avm_m0_readdatavalid && !abort_pend_q;
    assign pop   = (wr_state_q == WR_BURST) && !avm_m1_waitrequest;
    assign flush = abort_pend_q && (rd_state_q == RD_IDLE) && (wr_state_q == WR_IDLE);

    assign rd_n = (rd_rem_q > MAX_B) ? MAX_B : rd_rem_q;
    assign wr_m = (wr_rem_q > MAX_B) ? MAX_B : wr_rem_q;

    // Free space is judged on next-cycle occupancy; a new read request is only
    // issued with no beats outstanding, so this reserves room for all n beats.
    assign rd_free = CNT_W'(FIFO_DEPTH) - fifo_cnt_d;
    assign rd_go   = busy_q && !abort_pend_q && (rd_rem_q != '0) && (ADDR_W'(rd_free) >= rd_n);
    assign wr_go   = busy_q && !abort_pend_q && (wr_rem_q != '0) && (ADDR_W'(fifo_cnt_q) >= wr_m);

    always_comb begin
        fifo_wp_d  = fifo_wp_q + PTR_W'(push);
        fifo_rp_d  = fifo_rp_q + PTR_W'(pop);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            fifo_wp_d  = '0;
            fifo_rp_d  = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wp_q] <= avm_m0_readdata;
    end

`ifdef BPFCAP_DMA_PERF_EN
    logic [31:0] perf_q, perf_d;
    always_comb begin
        perf_d = perf_q;
        if (start_acc) perf_d = '0;
        else if (busy_q && (perf_q != '1)) perf_d = perf_q + 32'd1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end
    assign perf_rd = perf_q;
`else
    assign perf_rd = '0;
`endif

    always_comb begin
        irq_en_d = irq_en_q;   busy_d = busy_q;       done_d = done_q;
        err_d = err_q;         aborted_d = aborted_q; abort_pend_d = abort_pend_q;
        src_begin_d = src_begin_q; src_end_d = src_end_q; dst_addr_d = dst_addr_q;
        rd_state_d = rd_state_q; rd_src_d = rd_src_q; rd_rem_d = rd_rem_q;
        rd_len_d = rd_len_q;     rd_beats_d = rd_beats_q;
        wr_state_d = wr_state_q; wr_dst_d = wr_dst_q; wr_rem_d = wr_rem_q;
        wr_len_d = wr_len_q;     wr_beats_d = wr_beats_q;
        bytes_d = bytes_q;       rdata_d = rdata_q;

        if (avs_s0_read) begin
            case (avs_s0_address)
                3'd0:    rdata_d = {30'd0, irq_en_q, 1'b0};
                3'd1:    rdata_d = 32'(src_begin_q);
                3'd2:    rdata_d = 32'(src_end_q);
                3'd3:    rdata_d = 32'(dst_addr_q);
                3'd4:    rdata_d = {28'd0, aborted_q, err_q, done_q, busy_q};
                3'd5:    rdata_d = bytes_q;
                3'd6:    rdata_d = perf_rd;
                default: rdata_d = '0;
            endcase
        end

        if (avs_s0_write) begin
            case (avs_s0_address)
                3'd0: irq_en_d = avs_s0_writedata[1];
                3'd1: if (!busy_q) src_begin_d = ADDR_W'(avs_s0_writedata);
                3'd2: if (!busy_q) src_end_d   = ADDR_W'(avs_s0_writedata);
                3'd3: if (!busy_q) dst_addr_d  = ADDR_W'(avs_s0_writedata);
                3'd4: begin
                    if (avs_s0_writedata[1]) done_d    = 1'b0;
                    if (avs_s0_writedata[2]) err_d     = 1'b0;
                    if (avs_s0_writedata[3]) aborted_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (start_cmd && !abort_cmd && !busy_q) begin
            if (len_bad) begin
                err_d = 1'b1;
            end else begin
                busy_d    = 1'b1;
                done_d    = 1'b0;
                err_d     = 1'b0;
                aborted_d = 1'b0;
                bytes_d   = '0;
                rd_rem_d  = words;
                wr_rem_d  = words;
                rd_src_d  = src_begin_q;
                wr_dst_d  = dst_addr_q;
            end
        end
        if (abort_cmd && busy_q) abort_pend_d = 1'b1;

        case (rd_state_q)
            RD_IDLE: if (rd_go) begin
                rd_state_d = RD_REQ;
                rd_len_d   = rd_n[15:0];
            end
            RD_REQ: if (!avm_m0_waitrequest) begin
                rd_state_d = RD_DATA;
                rd_beats_d = rd_len_q;
                rd_src_d   = rd_src_q + ADDR_W'(rd_len_q) * BPW_A;
                rd_rem_d   = rd_rem_q - ADDR_W'(rd_len_q);
            end
            RD_DATA: if (avm_m0_readdatavalid) begin
                rd_beats_d = rd_beats_q - 16'd1;
                if (rd_beats_q == 16'd1) begin
                    rd_state_d = rd_go ? RD_REQ : RD_IDLE;
                    rd_len_d   = rd_n[15:0];
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        case (wr_state_q)
            WR_IDLE: if (wr_go) begin
                wr_state_d = WR_BURST;
                wr_len_d   = wr_m[15:0];
                wr_beats_d = wr_m[15:0];
            end
            WR_BURST: if (!avm_m1_waitrequest) begin
                bytes_d    = bytes_q + 32'(BPW);
                wr_beats_d = wr_beats_q - 16'd1;
                if (wr_beats_q == 16'd1) begin
                    wr_state_d = WR_IDLE;
                    wr_dst_d   = wr_dst_q + ADDR_W'(wr_len_q) * BPW_A;
                    wr_rem_d   = wr_rem_q - ADDR_W'(wr_len_q);
                    // A pending abort reports ABORTED via the flush path instead.
                    if ((wr_rem_q == ADDR_W'(wr_len_q)) && !abort_pend_q) begin
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        abort_pend_d = 1'b0;
                    end
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        if (flush) begin
            busy_d       = 1'b0;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state_q <= RD_IDLE;  wr_state_q <= WR_IDLE;
            irq_en_q <= 1'b0;       busy_q <= 1'b0;       done_q <= 1'b0;
            err_q <= 1'b0;          aborted_q <= 1'b0;    abort_pend_q <= 1'b0;
            src_begin_q <= '0;      src_end_q <= '0;      dst_addr_q <= '0;
            rd_src_q <= '0;         rd_rem_q <= '0;       rd_len_q <= '0;  rd_beats_q <= '0;
            wr_dst_q <= '0;         wr_rem_q <= '0;       wr_len_q <= '0;  wr_beats_q <= '0;
            bytes_q <= '0;          rdata_q <= '0;
            fifo_wp_q <= '0;        fifo_rp_q <= '0;      fifo_cnt_q <= '0;
        end else begin
            rd_state_q <= rd_state_d;  wr_state_q <= wr_state_d;
            irq_en_q <= irq_en_d;      busy_q <= busy_d;        done_q <= done_d;
            err_q <= err_d;            aborted_q <= aborted_d;  abort_pend_q <= abort_pend_d;
            src_begin_q <= src_begin_d; src_end_q <= src_end_d; dst_addr_q <= dst_addr_d;
            rd_src_q <= rd_src_d;      rd_rem_q <= rd_rem_d;    rd_len_q <= rd_len_d;  rd_beats_q <= rd_beats_d;
            wr_dst_q <= wr_dst_d;      wr_rem_q <= wr_rem_d;    wr_len_q <= wr_len_d;  wr_beats_q <= wr_beats_d;
            bytes_q <= bytes_d;        rdata_q <= rdata_d;
            fifo_wp_q <= fifo_wp_d;    fifo_rp_q <= fifo_rp_d;  fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
    assert property (@(posedge clk) disable iff (!reset) !(pop && (fifo_cnt_q == '0)));

    assign avs_s0_readdata   = rdata_q;
    assign irq               = done_q & irq_en_q;
    assign avm_m0_read       = (rd_state_q == RD_REQ);
    assign avm_m0_address    = avm_m0_read ? rd_src_q : '0;
    assign avm_m0_burstcount = avm_m0_read ? rd_len_q : '0;
    assign avm_m1_write      = (wr_state_q == WR_BURST);
    assign avm_m1_address    = avm_m1_write ? wr_dst_q : '0;
    assign avm_m1_burstcount = avm_m1_write ? wr_len_q : '0;
    assign avm_m1_writedata  = avm_m1_write ? fifo_mem[fifo_rp_q] : '0;
endmodule

// File: tb/tb_bpfcap_dma.sv
module tb_bpfcap_dma;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  avs_s0_address = '0;
    logic [31:0] avs_s0_writedata = '0;
    logic        avs_s0_write = 1'b0;
    logic        avs_s0_read = 1'b0;
    logic [31:0] avs_s0_readdata;
    logic [31:0] avm_m0_address, avm_m1_address, avm_m0_readdata, avm_m1_writedata;
    logic        avm_m0_read, avm_m0_readdatavalid, avm_m0_waitrequest;
    logic        avm_m1_write, avm_m1_waitrequest, irq;
    logic [15:0] avm_m0_burstcount, avm_m1_burstcount;

    always #5 clk = ~clk;

    bpfcap_dma dut (
        .clk(clk), .reset(reset),
        .avs_s0_address(avs_s0_address), .avs_s0_writedata(avs_s0_writedata),
        .avs_s0_write(avs_s0_write), .avs_s0_read(avs_s0_read), .avs_s0_readdata(avs_s0_readdata),
        .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read),
        .avm_m0_burstcount(avm_m0_burstcount), .avm_m0_readdata(avm_m0_readdata),
        .avm_m0_readdatavalid(avm_m0_readdatavalid), .avm_m0_waitrequest(avm_m0_waitrequest),
        .avm_m1_address(avm_m1_address), .avm_m1_writedata(avm_m1_writedata),
        .avm_m1_write(avm_m1_write), .avm_m1_burstcount(avm_m1_burstcount),
        .avm_m1_waitrequest(avm_m1_waitrequest), .irq(irq)
    );

    int          n_vec = 0, n_bad = 0;
    int          wait_pct = 0;
    int          stab_err = 0, dup_err = 0;
    logic [31:0] seed = 32'h1234_5678;
    logic [31:0] model_bytes = 0;
    logic [31:0] rd_log_a[$], rd_log_n[$], wr_log_a[$], wr_log_n[$];
    logic [31:0] pend_a[$];
    logic [31:0] dst_mem[logic [31:0]];

    typedef struct {
        logic [31:0] b, e, d;
        int          wp;
        logic        ie;
        logic [3:0]  st;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Read-side memory slave: random stalls, beats returned from the cycle after acceptance.
    initial begin : rd_slave
        logic        in_req;
        logic [31:0] ra, rn;
        in_req = 1'b0; ra = '0; rn = '0;
        avm_m0_waitrequest = 1'b0; avm_m0_readdatavalid = 1'b0; avm_m0_readdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_req = 1'b0; pend_a.delete();
                avm_m0_waitrequest = 1'b0; avm_m0_readdatavalid = 1'b0;
                continue;
            end
            avm_m0_readdatavalid = 1'b0;
            if (pend_a.size() > 0 && int'($urandom_range(99)) >= wait_pct) begin
                avm_m0_readdatavalid = 1'b1;
                avm_m0_readdata = src_word(pend_a.pop_front());
            end
            avm_m0_waitrequest = (int'($urandom_range(99)) < wait_pct);
            if (avm_m0_read) begin
                if (!in_req) begin
                    in_req = 1'b1; ra = avm_m0_address; rn = 32'(avm_m0_burstcount);
                end else if (avm_m0_address != ra || 32'(avm_m0_burstcount) != rn) begin
                    stab_err++;
                end
                if (!avm_m0_waitrequest) begin
                    in_req = 1'b0;
                    rd_log_a.push_back(ra); rd_log_n.push_back(rn);
                    for (int k = 0; k < int'(rn); k++) pend_a.push_back(ra + 32'(k) * 4);
                end
            end
        end
    end

    // Write-side memory slave: random stalls, records every accepted beat.
    initial begin : wr_slave
        logic        in_b;
        logic [31:0] wa, wn, idx, a;
        in_b = 1'b0; wa = '0; wn = '0; idx = '0;
        avm_m1_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_b = 1'b0; avm_m1_waitrequest = 1'b0;
                continue;
            end
            avm_m1_waitrequest = (int'($urandom_range(99)) < wait_pct);
            if (avm_m1_write) begin
                if (!in_b) begin
                    in_b = 1'b1; wa = avm_m1_address; wn = 32'(avm_m1_burstcount); idx = 0;
                    wr_log_a.push_back(wa); wr_log_n.push_back(wn);
                end else if (avm_m1_address != wa || 32'(avm_m1_burstcount) != wn) begin
                    stab_err++;
                end
                if (!avm_m1_waitrequest) begin
                    a = wa + idx * 4;
                    if (dst_mem.exists(a)) dup_err++;
                    dst_mem[a] = avm_m1_writedata;
                    idx++;
                    if (idx == wn) in_b = 1'b0;
                end
            end
        end
    end

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_s0_address = a; avs_s0_writedata = d; avs_s0_write = 1'b1;
        @(negedge clk);
        avs_s0_write = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_s0_address = a; avs_s0_read = 1'b1;
        @(negedge clk);
        avs_s0_read = 1'b0;
        d = avs_s0_readdata;
    endtask

    task automatic wait_idle(output logic [31:0] s);
        s = 32'h1;
        for (int g = 0; g < 3000 && s[0]; g++) reg_read(3'd4, s);
        chk("busy_timeout", {31'd0, s[0]}, 32'd0);
    endtask

    task automatic clear_logs();
        rd_log_a.delete(); rd_log_n.delete(); wr_log_a.delete(); wr_log_n.delete();
        dst_mem.delete();
    endtask

    // Reference: bursts are min(16, words left) long, at consecutive addresses on
    // both sides; destination word i equals source word i.
    task automatic run_copy(input string nm, input logic [31:0] b, input logic [31:0] e,
                            input logic [31:0] d, input int wp, input logic ie, input logic [3:0] st);
        logic [31:0] s, v, len, rem, off, n, bad, a;
        int          nb;
        wait_pct = wp;
        seed = $urandom;
        clear_logs();
        reg_write(3'd1, b); reg_write(3'd2, e); reg_write(3'd3, d);
        reg_write(3'd4, 32'hE);
        reg_write(3'd0, {30'd0, ie, 1'b1});
        wait_idle(s);
        chk({nm, "_status"}, {28'd0, s[3:0]}, {28'd0, st});
        len = e - b;
        if (st == 4'h2) begin
            model_bytes = len;
            rem = len / 4; off = 0; nb = 0;
            while (rem != 0) begin
                n = (rem > 16) ? 32'd16 : rem;
                if (nb < rd_log_a.size()) begin
                    chk({nm, "_rd_addr"}, rd_log_a[nb], b + off);
                    chk({nm, "_rd_burst"}, rd_log_n[nb], n);
                end
                if (nb < wr_log_a.size()) begin
                    chk({nm, "_wr_addr"}, wr_log_a[nb], d + off);
                    chk({nm, "_wr_burst"}, wr_log_n[nb], n);
                end
                off += n * 4; rem -= n; nb++;
            end
            chk({nm, "_rd_bursts"}, 32'(rd_log_a.size()), 32'(nb));
            chk({nm, "_wr_bursts"}, 32'(wr_log_a.size()), 32'(nb));
            bad = 0;
            for (int i = 0; i < int'(len / 4); i++) begin
                a = d + 32'(i) * 4;
                if (!dst_mem.exists(a) || dst_mem[a] !== src_word(b + 32'(i) * 4)) bad++;
            end
            chk({nm, "_data_bad"}, bad, 0);
            chk({nm, "_words"}, 32'(dst_mem.size()), len / 4);
        end else begin
            chk({nm, "_no_rd"}, 32'(rd_log_a.size()), 0);
            chk({nm, "_no_wr"}, 32'(wr_log_a.size()), 0);
        end
        reg_read(3'd5, v);
        chk({nm, "_bytes"}, v, model_bytes);
        chk({nm, "_irq"}, {31'd0, irq}, {31'd0, ie & st[1]});
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] v, s, b, e, d, bytes_ab;
        logic [3:0]  st;

        tbl[0] = '{32'h1000, 32'h1100, 32'h8000, 0,  1'b0, 4'h2};
        tbl[1] = '{32'h1000, 32'h1014, 32'h9000, 0,  1'b0, 4'h2};
        tbl[2] = '{32'h2000, 32'h2100, 32'hA000, 50, 1'b0, 4'h2};
        tbl[3] = '{32'h3000, 32'h3006, 32'hA000, 0,  1'b0, 4'h4};
        tbl[4] = '{32'h3100, 32'h3000, 32'hA000, 0,  1'b0, 4'h4};
        tbl[5] = '{32'h3000, 32'h3000, 32'hA000, 0,  1'b0, 4'h4};
        tbl[6] = '{32'h4000, 32'h4040, 32'hB000, 30, 1'b1, 4'h2};

        repeat (3) @(negedge clk);
        chk("rst_read", {31'd0, avm_m0_read}, 0);
        chk("rst_write", {31'd0, avm_m1_write}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        chk("rst_readdata", avs_s0_readdata, 0);
        reset = 1'b1;
        reg_read(3'd4, v); chk("rst_status", v, 0);
        reg_read(3'd5, v); chk("rst_bytes", v, 0);
        reg_read(3'd7, v); chk("reg7", v, 0);
        reg_read(3'd6, v); chk("reg6_idle", v, 0);
        reg_write(3'd0, 32'h2);
        reg_read(3'd0, v); chk("ctrl_rb", v, 32'h2);
        repeat (3) @(negedge clk);
        chk("readdata_hold", avs_s0_readdata, 32'h2);

        for (int i = 0; i < 7; i++)
            run_copy($sformatf("tbl%0d", i), tbl[i].b, tbl[i].e, tbl[i].d, tbl[i].wp, tbl[i].ie, tbl[i].st);

        // DONE with IRQ_EN set from the last table row; clearing DONE drops irq.
        reg_write(3'd4, 32'h2);
        chk("irq_clear", {31'd0, irq}, 0);

        for (int i = 0; i < 4; i++) begin
            b = 32'h10000 + $urandom_range(255) * 4;
            e = b + $urandom_range(1, 70) * 4 + ((i == 2) ? 32'd2 : 32'd0);
            d = 32'h40000 + $urandom_range(255) * 4;
            st = ((e - b) != 0 && (e - b) % 4 == 0 && e >= b) ? 4'h2 : 4'h4;
            run_copy($sformatf("rnd%0d", i), b, e, d, 50, 1'b0, st);
        end

        // ABORT during the second read burst.
        wait_pct = 0; seed = $urandom;
        clear_logs();
        reg_write(3'd1, 32'h1000); reg_write(3'd2, 32'h1100); reg_write(3'd3, 32'h8000);
        reg_write(3'd4, 32'hE); reg_write(3'd0, 32'h1);
        for (int g = 0; g < 2000 && rd_log_a.size() < 2; g++) @(negedge clk);
        chk("abort_reach_b2", 32'(rd_log_a.size()), 2);
        reg_write(3'd1, 32'hDEAD_0000);
        reg_write(3'd0, 32'h4);
        wait_idle(s);
        chk("abort_status", s, 32'h8);
        chk("abort_rd_bursts", 32'(rd_log_a.size()), 2);
        reg_read(3'd5, bytes_ab);
        chk("abort_bytes_lt", {31'd0, bytes_ab < 256}, 1);
        chk("abort_bytes_mod", bytes_ab % 4, 0);
        chk("abort_bytes_obs", bytes_ab, 32'(dst_mem.size()) * 4);
        reg_read(3'd1, v); chk("busy_wr_ignored", v, 32'h1000);
        model_bytes = bytes_ab;
        // Stale FIFO contents would corrupt this copy.
        run_copy("post_abort", 32'h5000, 32'h5080, 32'hC000, 0, 1'b0, 4'h2);

        // START and ABORT together: nothing starts.
        clear_logs();
        reg_write(3'd4, 32'hE);
        reg_write(3'd0, 32'h5);
        repeat (20) @(negedge clk);
        reg_read(3'd4, v); chk("start_abort_status", v, 0);
        chk("start_abort_no_rd", 32'(rd_log_a.size()), 0);

        // ABORT while idle is ignored.
        reg_write(3'd0, 32'h4);
        reg_read(3'd4, v); chk("idle_abort_status", v, 0);

        chk("addr_stable", 32'(stab_err), 0);
        chk("no_dup", 32'(dup_err), 0);

        // Reset mid-transfer.
        wait_pct = 0; clear_logs();
        reg_write(3'd1, 32'h1000); reg_write(3'd2, 32'h1100); reg_write(3'd3, 32'h8000);
        reg_write(3'd0, 32'h3);
        repeat (30) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_read", {31'd0, avm_m0_read}, 0);
        chk("midrst_write", {31'd0, avm_m1_write}, 0);
        chk("midrst_readdata", avs_s0_readdata, 0);
        reset = 1'b1;
        reg_read(3'd4, v); chk("midrst_status", v, 0);
        reg_read(3'd5, v); chk("midrst_bytes", v, 0);
        reg_read(3'd1, v); chk("midrst_src", v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bpfcap_dma.md
Name: bpfcap_dma

Overview:
Parametrised successor to the capture-path copy engine. Copies a packet buffer `[SRC_BEGIN, SRC_END)` to `DST_ADDR` through an internal FIFO, using full Avalon-MM bursts with waitrequest honoured on both masters. Adds over the previous generation: configurable width, depth and burst size, abort, done/error status, interrupt, and a bytes-copied counter. Sits between the OS-facing register slave and the SDRAM/HPS bridge.

Parameters:
- DATA_W, 32, data width of both masters in bits; a multiple of 8.
- ADDR_W, 32, byte address width of both masters.
- FIFO_DEPTH, 64, FIFO depth in words; a power of 2 and ≥ 2*MAX_BURST.
- MAX_BURST, 16, maximum burstcount per transaction; a power of 2, ≤ 256.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- avs_s0_address  in  3  register word index.
- avs_s0_writedata  in  32  register write data.
- avs_s0_write  in  1  register write strobe.
- avs_s0_read  in  1  register read strobe.
- avs_s0_readdata  out  32  register read data; valid 1 cycle after the read.
- avm_m0_address  out  ADDR_W  read-master byte address.
- avm_m0_read  out  1  read request.
- avm_m0_burstcount  out  16  read burst length.
- avm_m0_readdata  in  DATA_W  returned read data.
- avm_m0_readdatavalid  in  1  read data beat valid.
- avm_m0_waitrequest  in  1  read-master stall.
- avm_m1_address  out  ADDR_W  write-master byte address.
- avm_m1_writedata  out  DATA_W  write data.
- avm_m1_write  out  1  write request.
- avm_m1_burstcount  out  16  write burst length.
- avm_m1_waitrequest  in  1  write-master stall.
- irq  out  1  level interrupt; asserted while DONE and IRQ_EN are both set.

Behaviour:
- Registers (BPW = DATA_W/8 bytes per word):
  - 0 CONTROL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN, bit2 ABORT (write-1 pulse, reads 0).
  - 1 SRC_BEGIN.
  - 2 SRC_END.
  - 3 DST_ADDR.
  - 4 STATUS: bit0 BUSY, bit1 DONE, bit2 ERROR, bit3 ABORTED. Writing 1 to bits 1–3 clears them.
  - 5 BYTES_COPIED.
  - 6 PERF (optional feature).
  - 7 reads 0.
- Register write rules:
  - Writes to registers 1–3 while BUSY are ignored.
  - Reads of unused bits return 0.
  - Readdata is registered and holds its value when no read is issued.
- Reset: all registers, counters and FIFO pointers clear to 0. All master outputs go to 0, irq to 0, and avs_s0_readdata to 0. Both FSMs go to IDLE.
- START while idle:
  - Compute LEN = SRC_END - SRC_BEGIN (ADDR_W-bit, unsigned).
  - If LEN == 0 or LEN is not a multiple of BPW, or if SRC_END < SRC_BEGIN: set ERROR and do no bus traffic.
  - Otherwise set BUSY, clear DONE/ERROR/ABORTED, zero BYTES_COPIED, and load WORDS = LEN/BPW into both the read and write remaining counters.
  - START while BUSY is ignored.
- Read FSM (IDLE → RD_REQ → RD_DATA → RD_REQ | IDLE):
  - RD_REQ is entered only when FIFO free space ≥ n, where n = min(MAX_BURST, rd_remaining). FIFO free space counts words still outstanding.
  - In RD_REQ, assert read with address = current source and burstcount = n. Hold all three stable while waitrequest = 1. The request is accepted on the first cycle with waitrequest = 0.
  - After acceptance: address += n*BPW and rd_remaining -= n.
  - In RD_DATA, every readdatavalid beat is pushed to the FIFO. Return to RD_REQ or IDLE after n beats.
- Write FSM (IDLE → WR_BURST → IDLE):
  - Starts when FIFO count ≥ m, where m = min(MAX_BURST, wr_remaining).
  - Asserts write with burstcount = m and writedata = FIFO head. Address and burstcount are held for the whole burst.
  - A beat completes, and the FIFO pops, on each cycle with write = 1 and waitrequest = 0.
  - Each completed beat adds BPW to BYTES_COPIED.
  - After m beats: dst += m*BPW and wr_remaining -= m.
  - When wr_remaining reaches 0: clear BUSY and set DONE, both 1 cycle after the last accepted beat.
- FIFO:
  - Same-cycle push and pop leave the count unchanged.
  - Push into a full FIFO or pop from an empty one is impossible by construction; assert this in simulation.
- ABORT while BUSY:
  - No new read or write bursts start.
  - An in-flight read burst is drained and its data discarded.
  - An in-flight write burst completes.
  - Then flush the FIFO, clear BUSY, and set ABORTED (not DONE).
  - ABORT while idle is ignored.
- Simultaneous START and ABORT in one write: ABORT wins, so nothing starts.
- Reset mid-transfer returns everything to the reset state immediately. No bus cleanup is performed.

Optional Feature:
- Macro BPFCAP_DMA_PERF_EN.
- When defined: register 6 is a 32-bit counter that clears on accepted START and increments every cycle BUSY = 1. It saturates at 0xFFFF_FFFF.
- When undefined: no counter logic; register 6 reads 0.

Test Plan:
- SRC_BEGIN = 0x1000, SRC_END = 0x1100, DST = 0x8000, START → read bursts of 16,16,16,16 from 0x1000/0x1040/0x1080/0x10C0; writes mirror them to 0x8000+; DONE = 1, BYTES_COPIED = 256, data matches.
- SRC_END = 0x1000 + 20 (5 words), MAX_BURST = 16 → a single read burst and a single write burst with burstcount = 5; DONE set.
- Random waitrequest on both masters at 50% during a 256-byte copy → address and burstcount stable while stalled; no lost or duplicated words.
- SRC_END = SRC_BEGIN + 6, then START → ERROR = 1, BUSY = 0, no read or write asserted.
- ABORT during the second read burst → that burst is drained; ABORTED = 1; BYTES_COPIED < 256 and a multiple of 4; FIFO empty.
- IRQ_EN = 1, copy completes → irq = 1; write 0x2 to STATUS → irq = 0 the next cycle.
